// File: rtl/cla_adder_16bit.sv
// -----------------------------------------------------------------------------
// cla_adder_16bit
// 16-bit two-level carry-lookahead adder with a single output register stage.
// Four 4-bit lookahead blocks produce block generate/propagate, and a
// second-level lookahead unit derives the inter-block carries, the carry-out
// and the 16-bit group generate/propagate.
//
// Ports:
//   clock    in   1   system clock, rising-edge active
//   clear    in   1   asynchronous active-high reset
//   A        in  16   operand A
//   B        in  16   operand B
//   Cin      in   1   carry into bit 0
//   S        out 16   registered sum, A + B + Cin modulo 2^16
//   C_out    out  1   registered carry out of bit 15
//   G_prime  out  1   registered group generate (independent of Cin)
//   P_prime  out  1   registered group propagate (independent of Cin)
//   V        out  1   registered two's-complement overflow, c16 ^ c15
//                     (present only when CLA_OVERFLOW_EN is defined)
//
// Optional feature macro: CLA_OVERFLOW_EN
// -----------------------------------------------------------------------------
module cla_adder_16bit (
  input  logic        clock,
  input  logic        clear,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        C_out,
  output logic        G_prime,
  output logic        P_prime
`ifdef CLA_OVERFLOW_EN
  ,
  output logic        V
`endif
);

  localparam int unsigned Width    = 16;
  localparam int unsigned BlkW     = 4;
  localparam int unsigned NumBlk   = Width / BlkW;

  logic [Width-1:0]  g;        // bit generate
  logic [Width-1:0]  p;        // bit propagate
  logic [Width-1:0]  c;        // carry into each bit
  logic [NumBlk-1:0] gg;       // block generate
  logic [NumBlk-1:0] pg;       // block propagate
  logic [NumBlk-1:0] bc;       // carry into each block
  logic              grp_g;
  logic              grp_p;
  logic              c16;

  logic [Width-1:0]  s_d,  s_q;
  logic              co_d, co_q;
  logic              gp_d, gp_q;
  logic              pp_d, pp_q;

  // Bit-level generate/propagate and block-level GG/PG.
  always_comb begin
    g  = A & B;
    p  = A ^ B;
    gg = '0;
    pg = '0;
    for (int b = 0; b < int'(NumBlk); b++) begin
      gg[b] = g[4*b+3]
            | (p[4*b+3] & g[4*b+2])
            | (p[4*b+3] & p[4*b+2] & g[4*b+1])
            | (p[4*b+3] & p[4*b+2] & p[4*b+1] & g[4*b]);
      pg[b] = p[4*b+3] & p[4*b+2] & p[4*b+1] & p[4*b];
    end
  end

  // Second-level lookahead: block carries and group G/P, all fully expanded.
  always_comb begin
    bc[0] = Cin;
    bc[1] = gg[0] | (pg[0] & Cin);
    bc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & Cin);
    bc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
          | (pg[2] & pg[1] & pg[0] & Cin);
    grp_g = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
          | (pg[3] & pg[2] & pg[1] & gg[0]);
    grp_p = pg[3] & pg[2] & pg[1] & pg[0];
    c16   = grp_g | (grp_p & Cin);
  end

  // Intra-block carries from each block's carry-in, expanded (no ripple).
  always_comb begin
    c = '0;
    for (int b = 0; b < int'(NumBlk); b++) begin
      c[4*b]   = bc[b];
      c[4*b+1] = g[4*b] | (p[4*b] & bc[b]);
      c[4*b+2] = g[4*b+1] | (p[4*b+1] & g[4*b])
               | (p[4*b+1] & p[4*b] & bc[b]);
      c[4*b+3] = g[4*b+2] | (p[4*b+2] & g[4*b+1])
               | (p[4*b+2] & p[4*b+1] & g[4*b])
               | (p[4*b+2] & p[4*b+1] & p[4*b] & bc[b]);
    end
  end

  // Next-state values for the output register.
  always_comb begin
    s_d  = p ^ c;
    co_d = c16;
    gp_d = grp_g;
    pp_d = grp_p;
  end

  // Output register stage.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      s_q  <= '0;
      co_q <= 1'b0;
      gp_q <= 1'b0;
      pp_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
      gp_q <= gp_d;
      pp_q <= pp_d;
    end
  end

  assign S       = s_q;
  assign C_out   = co_q;
  assign G_prime = gp_q;
  assign P_prime = pp_q;

`ifdef CLA_OVERFLOW_EN
  logic v_d, v_q;

  // Overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    v_d = c16 ^ c[Width-1];
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

  assign V = v_q;
`endif

endmodule

// File: tb/tb_cla_adder_16bit.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_16bit
// Directed-vector bench for cla_adder_16bit with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_cla_adder_16bit;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        gp;
    logic        pp;
    logic        v;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] S;
  logic        C_out;
  logic        G_prime;
  logic        P_prime;
`ifdef CLA_OVERFLOW_EN
  logic        V;
`endif

  int n_vec = 0;
  int n_err = 0;

  vec_t vecs[12];

  cla_adder_16bit dut (
    .clock   (clock),
    .clear   (clear),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .S       (S),
    .C_out   (C_out),
    .G_prime (G_prime),
    .P_prime (P_prime)
`ifdef CLA_OVERFLOW_EN
    ,
    .V       (V)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input int idx, input vec_t e);
    check($sformatf("v%0d.S", idx),  32'(S),       32'(e.s));
    check($sformatf("v%0d.Co", idx), 32'(C_out),   32'(e.co));
    check($sformatf("v%0d.G", idx),  32'(G_prime), 32'(e.gp));
    check($sformatf("v%0d.P", idx),  32'(P_prime), 32'(e.pp));
`ifdef CLA_OVERFLOW_EN
    check($sformatf("v%0d.V", idx),  32'(V),       32'(e.v));
`endif
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".S"},  32'(S),       32'h0);
    check({tag, ".Co"}, 32'(C_out),   32'h0);
    check({tag, ".G"},  32'(G_prime), 32'h0);
    check({tag, ".P"},  32'(P_prime), 32'h0);
`ifdef CLA_OVERFLOW_EN
    check({tag, ".V"},  32'(V),       32'h0);
`endif
  endtask

  initial begin
    //           a         b         cin   s         co    gp    pp    v
    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{16'hA0A0, 16'h0505, 1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};

    clear = 1'b1;
    A     = 16'hFFFF;
    B     = 16'hFFFF;
    Cin   = 1'b1;
    #1;
    check_zero("rst0");
    @(posedge clock);
    @(posedge clock);
    #1;
    check_zero("rst1");

    // Back-to-back: check previous vector's result, then drive the next one.
    @(negedge clock);
    clear = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) check_vec(i - 1, vecs[i-1]);
      if (i < 12) begin
        A   = vecs[i].a;
        B   = vecs[i].b;
        Cin = vecs[i].cin;
      end
      @(negedge clock);
    end

    // Result of the last vector must still be held (inputs unchanged).
    check_vec(11, vecs[11]);

    // Load a non-zero result, then assert clear between edges.
    A   = 16'hFFFF;
    B   = 16'hFFFF;
    Cin = 1'b0;
    @(negedge clock);
    check_vec(5, vecs[5]);
    #2;
    clear = 1'b1;
    #1;
    check_zero("clr_async");
    A   = vecs[0].a;
    B   = vecs[0].b;
    Cin = vecs[0].cin;
    @(posedge clock);
    #1;
    check_zero("clr_hold");

    // First edge after release captures the current operands.
    @(negedge clock);
    clear = 1'b0;
    #1;
    check_zero("clr_rel");
    @(posedge clock);
    #1;
    check_vec(0, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
